decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter_pkg.sv | 12 +
 rtl/decoder_rr_arbiter_rr_priority_pick.sv | 28 ++
 rtl/decoder_rr_arbiter.sv | 91 +++++++++
 tb/tb_decoder_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin decoder arbiter.
package decoder_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_pick
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] dbl;

  // Lower half holds only bits at/after ptr; upper half supplies the wrapped scan.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    dbl    = {req, masked};
    winner = '0;
    for (int i = 2 * int'(N_REQ) - 1; i >= 0; i--) begin
      if (dbl[i]) winner = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of a shared 4-to-16 decoder select/enable with a dead gap
// between owners and an optional maximum hold time.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_en,
  output logic             timeout
);

  localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   grant_idx_d;
  logic               grant_en_d;
  logic               timeout_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
  logic [IDX_W-1:0]   winner;
  logic               any;
  logic               rel_done, rel_drop, rel_hold;

  rr_priority_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_idx <= '0;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      hold_cnt  <= hold_cnt_d;
      grant_idx <= grant_idx_d;
      grant_en  <= grant_en_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    hold_cnt_d  = hold_cnt;
    grant_idx_d = grant_idx;
    grant_en_d  = grant_en;
    timeout_d   = 1'b0;
    rel_done    = 1'b0;
    rel_drop    = 1'b0;
    rel_hold    = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_d     = GRANT;
          grant_idx_d = winner;
          grant_en_d  = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        rel_done = done;
        rel_drop = !req[grant_idx];
        rel_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        // Any release goes through IDLE, which forms the one-cycle dead gap.
        if (rel_done || rel_drop || rel_hold) begin
          state_d    = IDLE;
          grant_en_d = 1'b0;
          ptr_d      = grant_idx + IDX_W'(1);
          timeout_d  = rel_hold && !rel_done && !rel_drop;
        end else begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: scoreboard of predicted outputs
// plus directed checks of the handover, wrap, timeout and reset behaviour.
module tb_decoder_rr_arbiter;
  import decoder_rr_arbiter_pkg::*;

  localparam int unsigned MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  grant_idx;
  logic        grant_en;
  logic        timeout;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: values the DUT outputs/internal regs should hold after the last edge.
  logic       m_en;
  logic [3:0] m_idx;
  int         m_ptr;
  int         m_hold;

  task automatic model_reset();
    m_en   = 1'b0;
    m_idx  = 4'd0;
    m_ptr  = 0;
    m_hold = 0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
  task automatic step(input logic [15:0] r, input logic d);
    exp_t e;
    exp_t q;
    logic found;
    logic a, b, c;
    @(negedge clk);
    req  = r;
    done = d;
    e.en  = m_en;
    e.idx = m_idx;
    e.to  = 1'b0;
    if (!m_en) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        int j;
        j = (m_ptr + k) % 16;
        if (!found && r[j]) begin
          found  = 1'b1;
          e.en   = 1'b1;
          e.idx  = 4'(j);
          m_hold = 0;
        end
      end
    end else begin
      a = d;
      b = !r[m_idx];
      c = (MAX_HOLD != 0) && (m_hold == int'(MAX_HOLD) - 1);
      if (a || b || c) begin
        e.en  = 1'b0;
        m_ptr = (int'(m_idx) + 1) % 16;
        e.to  = c && !a && !b;
      end else begin
        m_hold++;
      end
    end
    m_en  = e.en;
    m_idx = e.idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    q = sb.pop_front();
    total++;
    if (grant_en !== q.en) begin
      bad++;
      $display("FAIL sb_grant_en t=%0t got=%b want=%b", $time, grant_en, q.en);
    end
    total++;
    if (grant_idx !== q.idx) begin
      bad++;
      $display("FAIL sb_grant_idx t=%0t got=%0d want=%0d", $time, grant_idx, q.idx);
    end
    total++;
    if (timeout !== q.to) begin
      bad++;
      $display("FAIL sb_timeout t=%0t got=%b want=%b", $time, timeout, q.to);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    #1;
    total++;
    if ({grant_en, grant_idx, timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b idx=%0d to=%b want all zero", grant_en, grant_idx, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    test_reset();
    step(16'h0001, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd0) begin
      bad++;
      $display("FAIL single_grant got en=%b idx=%0d want en=1 idx=0", grant_en, grant_idx);
    end
    step(16'h0001, 1'b0);
    step(16'h0001, 1'b0);
    step(16'h0001, 1'b1);
    total++;
    if (grant_en !== 1'b0) begin
      bad++;
      $display("FAIL single_release got en=%b want 0", grant_en);
    end
    // ptr should now be 1: with bits 0 and 1 pending, 1 wins.
    step(16'h0003, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd1) begin
      bad++;
      $display("FAIL single_ptr got en=%b idx=%0d want en=1 idx=1", grant_en, grant_idx);
    end
    step(16'h0003, 1'b1);
    step(16'h0000, 1'b1);
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    test_reset();
    for (int g = 0; g < 5; g++) begin
      step(16'h8001, 1'b0);
      total++;
      if (grant_en !== 1'b1 || grant_idx !== seq[g]) begin
        bad++;
        $display("FAIL rotation_idx g=%0d got en=%b idx=%0d want en=1 idx=%0d", g, grant_en, grant_idx, seq[g]);
      end
      step(16'h8001, 1'b1);
      total++;
      if (grant_en !== 1'b0 || grant_idx !== seq[g]) begin
        bad++;
        $display("FAIL rotation_gap g=%0d got en=%b idx=%0d want en=0 idx=%0d", g, grant_en, grant_idx, seq[g]);
      end
    end
  endtask

  task automatic test_timeout();
    int high;
    test_reset();
    step(16'h0010, 1'b0);
    high = grant_en ? 1 : 0;
    for (int i = 0; i < 20 && grant_en; i++) begin
      step(16'h0010, 1'b0);
      if (grant_en) high++;
    end
    total++;
    if (high != 8) begin
      bad++;
      $display("FAIL timeout_len got=%0d want=8", high);
    end
    total++;
    if (timeout !== 1'b1 || grant_en !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse got to=%b en=%b want to=1 en=0", timeout, grant_en);
    end
    step(16'h0010, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd4 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_regrant got en=%b idx=%0d to=%b want en=1 idx=4 to=0", grant_en, grant_idx, timeout);
    end
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
  endtask

  task automatic test_simultaneous();
    test_reset();
    step(16'h0010, 1'b0);
    for (int i = 0; i < 7; i++) step(16'h0010, 1'b0);
    step(16'h0010, 1'b1);
    total++;
    if (grant_en !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL simul_release got en=%b to=%b want en=0 to=0", grant_en, timeout);
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_drop();
    test_reset();
    step(16'h0020, 1'b0);
    step(16'h0021, 1'b0);
    step(16'h0020, 1'b0);
    step(16'h0021, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd5) begin
      bad++;
      $display("FAIL drop_owner got en=%b idx=%0d want en=1 idx=5", grant_en, grant_idx);
    end
    step(16'h0001, 1'b0);
    total++;
    if (grant_en !== 1'b0) begin
      bad++;
      $display("FAIL drop_release got en=%b want 0", grant_en);
    end
    step(16'h0001, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd0) begin
      bad++;
      $display("FAIL drop_wrap got en=%b idx=%0d want en=1 idx=0", grant_en, grant_idx);
    end
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b1);
  endtask

  task automatic test_async_reset();
    test_reset();
    step(16'h0008, 1'b0);
    step(16'h0008, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (grant_en !== 1'b0 || grant_idx !== 4'd0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got en=%b idx=%0d to=%b want en=0 idx=0 to=0", grant_en, grant_idx, timeout);
    end
    model_reset();
    req = 16'h0004;
    @(negedge clk);
    rst = 1'b0;
    step(16'h0004, 1'b0);
    total++;
    if (grant_en !== 1'b1 || grant_idx !== 4'd2) begin
      bad++;
      $display("FAIL async_first got en=%b idx=%0d want en=1 idx=2", grant_en, grant_idx);
    end
    step(16'h0004, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic        d;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 16'($urandom);
      if (i % 50 > 35) r = 16'hFFFF;
      d = ($urandom_range(0, 5) == 0);
      step(r, d);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_drop();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
